// File: rtl/summator4_reg_pkg.sv
// Shared widths and defaults for the registered switch adder.
package summator4_reg_pkg;
    localparam int OPERAND_W        = 4;
    localparam int RESULT_W         = 5;
    localparam int SYNC_STAGES_DEF  = 2;
    localparam int SW_W             = 2 * OPERAND_W;
endpackage

// File: rtl/summator4_reg_full_adder.sv
// One-bit full adder cell for the ripple-carry chain.
// Latency: combinational. Backpressure: none.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/summator4_reg.sv
// Synchronized 4-bit + 4-bit switch adder driving five registered LEDs.
// Latency: SYNC_STAGES+1 edges from switch sample to LEDs. Backpressure: none, free-running.
module summator4_reg
    import summator4_reg_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic SW0,
    input  logic SW1,
    input  logic SW2,
    input  logic SW3,
    input  logic SW4,
    input  logic SW5,
    input  logic SW6,
    input  logic SW7,
    output logic LD3,
    output logic LD4,
    output logic LD5,
    output logic LD6,
    output logic LD7
);
    logic [SW_W-1:0]                   w_sw;
    logic [SYNC_STAGES-1:0][SW_W-1:0]  r_sync;
    logic [OPERAND_W-1:0]              w_a;
    logic [OPERAND_W-1:0]              w_b;
    logic [OPERAND_W-1:0]              w_sum;
    logic [OPERAND_W:0]                w_carry;
    logic [RESULT_W-1:0]               r_result;

    assign w_sw = {SW7, SW6, SW5, SW4, SW3, SW2, SW1, SW0};

    // Every switch bit gets its own flop chain; index 0 is the metastable stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= w_sw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_a        = r_sync[SYNC_STAGES-1][SW_W-1:OPERAND_W];
    assign w_b        = r_sync[SYNC_STAGES-1][OPERAND_W-1:0];
    assign w_carry[0] = 1'b0;

    for (genvar g = 0; g < OPERAND_W; g++) begin : g_ripple
        full_adder u_fa (
            .a    (w_a[g]),
            .b    (w_b[g]),
            .cin  (w_carry[g]),
            .s    (w_sum[g]),
            .cout (w_carry[g+1])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
        end else begin
            r_result <= {w_carry[OPERAND_W], w_sum};
        end
    end

    assign LD3 = r_result[0];
    assign LD4 = r_result[1];
    assign LD5 = r_result[2];
    assign LD6 = r_result[3];
    assign LD7 = r_result[4];
endmodule

// File: tb/tb_summator4_reg.sv
// Directed and exhaustive checks of the registered switch adder, including async reset.
module tb_summator4_reg;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sw  = 8'h00;
    logic       LD3, LD4, LD5, LD6, LD7;
    logic [4:0] ld;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    summator4_reg #(.SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .SW0 (sw[0]),
        .SW1 (sw[1]),
        .SW2 (sw[2]),
        .SW3 (sw[3]),
        .SW4 (sw[4]),
        .SW5 (sw[5]),
        .SW6 (sw[6]),
        .SW7 (sw[7]),
        .LD3 (LD3),
        .LD4 (LD4),
        .LD5 (LD5),
        .LD6 (LD6),
        .LD7 (LD7)
    );

    assign ld = {LD7, LD6, LD5, LD4, LD3};

    task automatic check(input string tag, input logic [4:0] exp);
        total++;
        assert (ld === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, ld, exp);
        end
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    // Apply at the falling edge, expect the old value for two edges, new on the third.
    task automatic vec(input string tag, input logic [7:0] v,
                       input logic [4:0] prev, input logic [4:0] exp);
        @(negedge clk);
        sw = v;
        edge_sample();
        check({tag, "_hold1"}, prev);
        edge_sample();
        check({tag, "_hold2"}, prev);
        edge_sample();
        check(tag, exp);
    endtask

    initial begin
        logic [4:0] model;
        logic       pulse;

        #2;
        check("reset_init", 5'b00000);
        repeat (2) edge_sample();
        check("reset_held", 5'b00000);

        @(negedge clk);
        sw  = 8'hFF;
        rst = 1'b0;
        repeat (3) edge_sample();
        check("ff_before_reset", 5'b11110);

        // Async reset between edges must clear the LEDs without a clock.
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_clear", 5'b00000);
        @(negedge clk);
        rst = 1'b0;
        edge_sample();
        check("post_reset_e1", 5'b00000);
        edge_sample();
        check("post_reset_e2", 5'b00000);
        edge_sample();
        check("post_reset_e3", 5'b11110);

        vec("a1_b0",   8'b0001_0000, 5'b11110, 5'b00001);
        vec("a5_b10",  8'b0101_1010, 5'b00001, 5'b01111);
        vec("a12_b7",  8'b1100_0111, 5'b01111, 5'b10011);
        vec("a7_b1",   8'b0111_0001, 5'b10011, 5'b01000);
        vec("a15_b15", 8'b1111_1111, 5'b01000, 5'b11110);
        vec("a0_b0",   8'b0000_0000, 5'b11110, 5'b00000);

        for (int v = 0; v < 256; v++) begin
            logic [7:0] vb;
            vb    = v[7:0];
            model = {1'b0, vb[7:4]} + {1'b0, vb[3:0]};
            pulse = ($urandom_range(0, 15) == 0);
            @(negedge clk);
            sw = vb;
            if (pulse) begin
                #1;
                rst = 1'b1;
                #1;
                check("exh_reset_clear", 5'b00000);
                #1;
                rst = 1'b0;
            end
            repeat (3) edge_sample();
            check("exhaustive_sum", model);
            edge_sample();
            check("exhaustive_hold", model);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/summator4_reg.md
Name: summator4_reg

Overview:
- Registered 4-bit unsigned adder driven by eight slide switches; result goes to five LEDs.
- Operand A = {SW7,SW6,SW5,SW4}, operand B = {SW3,SW2,SW1,SW0}, SW7/SW3 are the MSBs.
- Result = A+B, 5 bits: LD7 = carry-out, LD6..LD3 = sum[3:0].
- Switch inputs are asynchronous to clk, so they pass through a synchronizer before the adder. The result is held in an output register.

Parameters:
- SYNC_STAGES, 2, number of flip-flop stages in the switch synchronizer (legal values 2..3).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- SW0  in  1  operand B bit 0 (LSB); asynchronous.
- SW1  in  1  operand B bit 1; asynchronous.
- SW2  in  1  operand B bit 2; asynchronous.
- SW3  in  1  operand B bit 3 (MSB); asynchronous.
- SW4  in  1  operand A bit 0 (LSB); asynchronous.
- SW5  in  1  operand A bit 1; asynchronous.
- SW6  in  1  operand A bit 2; asynchronous.
- SW7  in  1  operand A bit 3 (MSB); asynchronous.
- LD3  out 1  sum bit 0.
- LD4  out 1  sum bit 1.
- LD5  out 1  sum bit 2.
- LD6  out 1  sum bit 3.
- LD7  out 1  carry-out (sum bit 4).

Behaviour:
- Reset:
  - rst=1 clears every synchronizer flop and the output register immediately, without waiting for clk.
  - LD7..LD3 = 00000 while rst is high.
  - Reset asserted mid-operation discards all in-flight values.
  - After rst falls, the first valid result appears SYNC_STAGES+1 rising edges after the switches are sampled.
- Synchronizer: each SW bit has its own SYNC_STAGES-deep flop chain. No debounce or filtering is applied.
- Adder:
  - Combinational 4-bit ripple-carry adder on the synchronized operands.
  - Carry-in fixed at 0.
  - Full 5-bit result, no overflow and no wrap; maximum is 15+15 = 30 = 11110.
- Output register: captures {carry, sum[3:0]} on every rising edge; LD outputs are driven only from this register.
- Latency:
  - A switch change that is stable before rising edge k is visible on the LEDs after edge k+SYNC_STAGES (3 edges for the default).
  - Outputs hold their value between updates.
- Simultaneous changes:
  - All eight SW bits changing in the same cycle land together on the LEDs, assuming setup is met.
  - A bit that violates setup may be delayed by one edge. That bit's effect is then seen one cycle later.
- There is no handshake and no enable; the block runs continuously.

Decomposition:
- Shared package holds:
  - constant OPERAND_W = 4;
  - constant RESULT_W = 5;
  - default SYNC_STAGES = 2.
- One sub-module: full_adder (a, b, cin -> s, cout), instantiated 4 times to form the ripple chain.
- Synchronizer and output register are written inline in summator4_reg.

Test Plan:
- Reset: drive SW=0xFF, assert rst asynchronously between clock edges → LD7..LD3 = 00000 immediately, before the next edge. Release rst → 11110 after 3 edges.
- A=1, B=0 (SW7..SW0 = 0001_0000) → after 3 edges LD7..LD3 = 00001.
- A=5, B=10 (0101_1010) → 01111. A=12, B=7 (1100_0111) → 10011, checking carry plus low bits.
- A=7, B=1 (0111_0001) → 01000, carry ripples through 3 stages.
- A=15, B=15 (1111_1111) → 11110. Check that LD holds the previous value for exactly 2 edges and updates on the 3rd.
- Exhaustive: all 256 switch combinations, each held 4 cycles → LEDs equal A+B. Also toggle rst randomly mid-sequence → outputs clear within the same cycle.
